alu_mc: RTL and testbench

Parametrised multi-cycle ALU with valid/ready handshakes on both input and output.
- Single-cycle operations complete with latency 1.
- Divide and remainder use an iterative restoring divider.
- Adds status flags (ZERO, ERR) and a variable shift amount.
- Sits between the register-file/controller path and the result consumer; replaces the fixed single-cycle ALU in the next system revision.

---
 rtl/alu_mc.sv | 137 +++++++++++++
 tb/tb_alu_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on input and output.
// Define ALU_DIV_EN to build the iterative restoring divider for opcodes 0011/1111.
module alu_mc #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = OPER_WIDTH*2,
  parameter int SH_WIDTH   = $clog2(OPER_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] A,
  input  logic [OPER_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  ZERO,
  output logic                  ERR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);
  function automatic logic [OUT_WIDTH-1:0] zx(input logic [OPER_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  logic [OUT_WIDTH-1:0] out_q, res_d;
  logic                 zero_q, err_q, ovld_q;
  logic                 err_d, is_div, idle, accept;

  always_comb begin
    res_d  = '0;
    err_d  = 1'b0;
    is_div = 1'b0;
    case (ALU_FUN)
      4'b0000: res_d = OUT_WIDTH'(A) + OUT_WIDTH'(B);
      4'b0001: res_d = OUT_WIDTH'(A) - OUT_WIDTH'(B);
      4'b0010: res_d = OUT_WIDTH'(A) * OUT_WIDTH'(B);
      4'b0100: res_d = zx(A & B);
      4'b0101: res_d = zx(A | B);
      4'b0110: res_d = zx(~(A & B));
      4'b0111: res_d = zx(~(A | B));
      4'b1000: res_d = zx(A ^ B);
      4'b1001: res_d = zx(~(A ^ B));
      4'b1010: res_d = (A == B) ? OUT_WIDTH'(1) : '0;
      4'b1011: res_d = (A > B)  ? OUT_WIDTH'(2) : '0;
      4'b1100: res_d = (A < B)  ? OUT_WIDTH'(3) : '0;
      4'b1101: res_d = zx(A >> B[SH_WIDTH-1:0]);
      4'b1110: res_d = OUT_WIDTH'(A) << B[SH_WIDTH-1:0];
`ifdef ALU_DIV_EN
      4'b0011: if (B == '0) begin res_d = zx('1); err_d = 1'b1; end else is_div = 1'b1;
      4'b1111: if (B == '0) begin res_d = zx(A);  err_d = 1'b1; end else is_div = 1'b1;
`else
      4'b0011, 4'b1111: err_d = 1'b1;
`endif
      default: res_d = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(OPER_WIDTH);
  typedef enum logic {IDLE, DIV} state_t;
  state_t                state_q;
  logic [OPER_WIDTH-1:0] rem_q, quo_q, dvs_q, rem_nx, quo_nx, diff;
  logic [CW-1:0]         cnt_q;
  logic                  sel_rem_q, ge;
  logic [OPER_WIDTH:0]   trial;
  logic [OUT_WIDTH-1:0]  div_res;

  // Restoring step: shift next dividend bit (quo_q MSB) into the partial remainder.
  assign trial   = {rem_q, quo_q[OPER_WIDTH-1]};
  assign ge      = trial >= {1'b0, dvs_q};
  assign diff    = trial[OPER_WIDTH-1:0] - dvs_q;
  assign rem_nx  = ge ? diff : trial[OPER_WIDTH-1:0];
  assign quo_nx  = {quo_q[OPER_WIDTH-2:0], ge};
  assign div_res = sel_rem_q ? zx(rem_nx) : zx(quo_nx);
  assign idle    = (state_q == IDLE);
`else
  assign idle    = 1'b1;
`endif

  assign IN_READY  = !RST && idle && (!ovld_q || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign ALU_OUT   = out_q;
  assign ZERO      = zero_q;
  assign ERR       = err_q;
  assign OUT_VALID = ovld_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      ovld_q <= 1'b0;
`ifdef ALU_DIV_EN
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
`endif
    end else begin
      if (ovld_q && OUT_READY) ovld_q <= 1'b0;
      // A load on the same edge as the drain wins, keeping OUT_VALID high.
      if (accept && !is_div) begin
        out_q  <= res_d;
        zero_q <= (res_d == '0);
        err_q  <= err_d;
        ovld_q <= 1'b1;
      end
`ifdef ALU_DIV_EN
      case (state_q)
        IDLE: if (accept && is_div) begin
          state_q   <= DIV;
          rem_q     <= '0;
          quo_q     <= A;
          dvs_q     <= B;
          cnt_q     <= '0;
          sel_rem_q <= ALU_FUN[3];
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(OPER_WIDTH-1)) begin
            state_q <= IDLE;
            out_q   <= div_res;
            zero_q  <= (div_res == '0);
            err_q   <= 1'b0;
            ovld_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed literal cases plus randomized traffic against a queue-based model.
module tb_alu_mc;
  localparam int OW = 8;
  localparam int RW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [OW-1:0] A = '0, B = '0;
  logic [3:0]    ALU_FUN = '0;
  logic          IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic          IN_READY, ZERO, ERR, OUT_VALID;
  logic [RW-1:0] ALU_OUT;

  alu_mc #(.OPER_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .ZERO(ZERO), .ERR(ERR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  initial forever #5 CLK = ~CLK;

  int  errs = 0, checks = 0, cyc = 0, busy_until = 0;
  bit  rnd_rdy = 1'b0;

  typedef struct { int res; bit err; int rdy; } exp_t;
  exp_t q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result, error flag and latency (accept to visible output) from the opcode table.
  function automatic void model(input int a, input int b, input bit [3:0] f,
                                output int r, output bit e, output int lat);
    int sh;
    sh  = b % OW;
    e   = 1'b0;
    lat = 1;
    r   = 0;
    case (f)
      4'd0:  r = a + b;
      4'd1:  r = (a - b) & 32'hFFFF;
      4'd2:  r = a * b;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = ~(a & b) & 255;
      4'd7:  r = ~(a | b) & 255;
      4'd8:  r = a ^ b;
      4'd9:  r = ~(a ^ b) & 255;
      4'd10: r = (a == b) ? 1 : 0;
      4'd11: r = (a > b) ? 2 : 0;
      4'd12: r = (a < b) ? 3 : 0;
      4'd13: r = a >> sh;
      4'd14: r = (a << sh) & 32'hFFFF;
      default: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin
          e = 1'b1;
          r = (f == 4'd3) ? 255 : a;
        end else begin
          r   = (f == 4'd3) ? a / b : a % b;
          lat = OW + 1;
        end
`else
        e = 1'b1;
        r = 0;
`endif
      end
    endcase
  endfunction

  always @(negedge CLK) begin
    int r, lat;
    bit e, eov, eir;
    if (RST) begin
      q.delete();
      busy_until = 0;
    end else begin
      eov = (q.size() > 0) && (cyc >= q[0].rdy);
      eir = (cyc >= busy_until) && (!eov || OUT_READY);
      chk("out_valid", 32'(OUT_VALID), 32'(eov));
      chk("in_ready", 32'(IN_READY), 32'(eir));
      if (eov && OUT_VALID) begin
        chk("alu_out", 32'(ALU_OUT), 32'(q[0].res));
        chk("zero", 32'(ZERO), 32'(q[0].res == 0));
        chk("err", 32'(ERR), 32'(q[0].err));
        if (OUT_READY) void'(q.pop_front());
      end
      if (IN_VALID && IN_READY) begin
        model(int'(A), int'(B), ALU_FUN, r, e, lat);
        q.push_back('{r, e, cyc + lat});
        busy_until = cyc + lat;
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    if (rnd_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input int a, input int b, input bit [3:0] f);
    int n;
    n = 0;
    A = OW'(a); B = OW'(b); ALU_FUN = f; IN_VALID = 1'b1;
    forever begin
      @(negedge CLK);
      if (IN_READY) break;
      n++;
      if (n > 40) begin chk("accept_timeout", 32'(0), 32'(1)); break; end
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int exp, input bit e, input int lat);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!OUT_VALID && n < 30);
    chk({nm, "_lat"},  32'(n), 32'(lat));
    chk({nm, "_out"},  32'(ALU_OUT), 32'(exp));
    chk({nm, "_err"},  32'(ERR), 32'(e));
    chk({nm, "_zero"}, 32'(ZERO), 32'(exp == 0));
    @(posedge CLK); #1;
  endtask

  initial begin
    int a, b, n;
    @(negedge CLK);
    chk("rst_out", 32'(ALU_OUT), 32'(0));
    chk("rst_valid", 32'(OUT_VALID), 32'(0));
    chk("rst_ready", 32'(IN_READY), 32'(0));
    repeat (2) @(posedge CLK);
    #2; RST = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;

    issue(200, 100, 4'b0000); expect_out("add", 16'h012C, 1'b0, 1);
`ifdef ALU_DIV_EN
    issue(200, 7, 4'b0011); expect_out("div", 28, 1'b0, 9);
    issue(200, 7, 4'b1111); expect_out("rem", 4, 1'b0, 9);
    issue(5, 0, 4'b0011);   expect_out("div0", 16'h00FF, 1'b1, 1);
    issue(5, 0, 4'b1111);   expect_out("rem0", 5, 1'b1, 1);
`else
    issue(200, 7, 4'b0011); expect_out("div_off", 0, 1'b1, 1);
    issue(5, 0, 4'b1111);   expect_out("rem_off", 0, 1'b1, 1);
`endif

    OUT_READY = 1'b0;
    issue(8'hF0, 8'hFF, 4'b1000);
    A = 8'd3; B = 8'd4; ALU_FUN = 4'b0000; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_ready", 32'(IN_READY), 32'(0));
      chk("bp_hold", 32'(ALU_OUT), 32'h000F);
      chk("bp_valid", 32'(OUT_VALID), 32'(1));
    end
    @(posedge CLK); #1; OUT_READY = 1'b1;
    @(negedge CLK); chk("bp_ready_go", 32'(IN_READY), 32'(1));
    @(posedge CLK); #1; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("bp_new_valid", 32'(OUT_VALID), 32'(1));
    chk("bp_new", 32'(ALU_OUT), 32'(7));
    @(posedge CLK); #1;

    issue(8'h81, 3, 4'b1110); expect_out("shl", 16'h0408, 1'b0, 1);
    issue(8'h81, 3, 4'b1101); expect_out("shr", 16'h0010, 1'b0, 1);
    issue(8'h81, 3, 4'b1011); expect_out("gt", 2, 1'b0, 1);
    issue(9, 9, 4'b1010);     expect_out("eq", 1, 1'b0, 1);
    issue(0, 0, 4'b0000);     expect_out("zero_add", 0, 1'b0, 1);

    issue(200, 7, 4'b0011);
    repeat (3) @(posedge CLK);
    #2; RST = 1'b1; #1;
    chk("mid_rst_out", 32'(ALU_OUT), 32'(0));
    chk("mid_rst_valid", 32'(OUT_VALID), 32'(0));
    chk("mid_rst_ready", 32'(IN_READY), 32'(0));
    chk("mid_rst_zero", 32'(ZERO), 32'(0));
    chk("mid_rst_err", 32'(ERR), 32'(0));
    repeat (2) @(posedge CLK);
    #2; RST = 1'b0;
    @(negedge CLK); chk("rst_rel_ready", 32'(IN_READY), 32'(1));
    @(posedge CLK); #1;
    issue(1, 2, 4'b0000); expect_out("post_rst_add", 3, 1'b0, 1);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      issue(a, b, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end

    rnd_rdy = 1'b0;
    @(posedge CLK); #2; OUT_READY = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin @(negedge CLK); n++; end
    chk("drain_empty", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
